// File: rtl/pwm_pkg.sv
// Shared types for the PWM configuration sequencer.
//   run_state_t : run-control FSM encoding (also driven out on RunState)
//   ADDR_*      : config bus register map
//   cfg_t       : the four words that make up one shadow or active config set
//   clampCmp    : limits a compare target to the carrier max count
package pwm_pkg;

  // Width of cfg_t fields; the sequencer's BIT_WIDTH defaults to this.
  localparam int CFG_W = 16;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    ARMED    = 3'd1,
    RUNNING  = 3'd2,
    STOPPING = 3'd3,
    FAULT    = 3'd4
  } run_state_t;

  localparam logic [2:0] ADDR_CMP    = 3'd0;
  localparam logic [2:0] ADDR_MAX    = 3'd1;
  localparam logic [2:0] ADDR_STEP   = 3'd2;
  localparam logic [2:0] ADDR_DEAD   = 3'd3;
  localparam logic [2:0] ADDR_RAMP   = 3'd4;
  localparam logic [2:0] ADDR_COMMIT = 3'd5;

  typedef struct packed {
    logic [CFG_W-1:0] compare;
    logic [CFG_W-1:0] maxCount;
    logic [CFG_W-1:0] stepSize;
    logic [CFG_W-1:0] deadTime;
  } cfg_t;

  function automatic logic [CFG_W-1:0] clampCmp(input logic [CFG_W-1:0] cmp,
                                                input logic [CFG_W-1:0] maxCount);
    return (cmp > maxCount) ? maxCount : cmp;
  endfunction

endpackage

// File: rtl/pwm_config_sequencer_if.sv
// Host configuration write channel.
//   CfgValid/CfgReady : write handshake, transfer when both high
//   CfgAddr/CfgData   : register address and write data
//   CfgErr            : one-cycle pulse on rejected commit or reserved address
// master = host side, slave = sequencer side.
interface pwm_config_sequencer_if #(parameter int BIT_WIDTH = 16);
  logic                 CfgValid;
  logic                 CfgReady;
  logic [2:0]           CfgAddr;
  logic [BIT_WIDTH-1:0] CfgData;
  logic                 CfgErr;

  modport master (output CfgValid, CfgAddr, CfgData, input CfgReady, CfgErr);
  modport slave  (input CfgValid, CfgAddr, CfgData, output CfgReady, CfgErr);
endinterface

// File: rtl/pwm_compare_ramp.sv
// Saturating step-toward-target register for the ramped compare value.
//   target  : value to approach
//   step    : increment per advance; 0 jumps straight to target
//   advance : take one step this cycle
//   clear   : force current to 0 (wins over advance)
//   current : registered ramp value
module pwm_compare_ramp
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = CFG_W
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic [BIT_WIDTH-1:0] target,
  input  logic [BIT_WIDTH-1:0] step,
  input  logic                 advance,
  input  logic                 clear,
  output logic [BIT_WIDTH-1:0] current
);

  logic [BIT_WIDTH:0]   upSum;
  logic [BIT_WIDTH:0]   dnDiff;
  logic [BIT_WIDTH-1:0] nxt;

  // One extra bit on both paths so a large step can neither wrap past the
  // top nor borrow below zero; either case just lands on the target.
  always_comb begin
    upSum  = {1'b0, current} + {1'b0, step};
    dnDiff = {1'b0, current} - {1'b0, step};
    nxt    = current;
    if (step == '0)
      nxt = target;
    else if (current < target)
      nxt = (upSum >= {1'b0, target}) ? target : upSum[BIT_WIDTH-1:0];
    else if (current > target)
      nxt = (dnDiff[BIT_WIDTH] || (dnDiff[BIT_WIDTH-1:0] <= target))
            ? target : dnDiff[BIT_WIDTH-1:0];
  end

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN)        current <= '0;
    else if (clear)   current <= '0;
    else if (advance) current <= nxt;
  end

endmodule

// File: rtl/pwm_config_sequencer.sv
// Run-control and configuration controller for the multi-phase PWM datapath.
//   MClk, RstN        : clock, async active-low reset
//   cfg (slave)       : host config writes, commit handshake and error pulse
//   Enable            : run request level
//   FaultIn           : external fault level, forces FAULT from any state
//   FaultClear        : fault acknowledge, must be held to leave FAULT
//   PeriodSync        : carrier-zero pulse from the datapath
//   Compare           : ramped compare value (0 outside RUNNING/STOPPING)
//   PWMMaxCount, TriangleStepSize, DeadTimeCount : active config
//   PWMRun            : datapath gate enable
//   RunState          : FSM state encoding
//   FaultLatched      : high while in FAULT
// Shadow registers are written freely; a commit copies them into the active
// set either immediately (idle states) or on the next carrier boundary.
module pwm_config_sequencer
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH        = CFG_W,  // must equal pwm_pkg::CFG_W
  parameter int FAULT_CLEAR_HOLD = 4
) (
  input  logic                  MClk,
  input  logic                  RstN,
  pwm_config_sequencer_if.slave cfg,
  input  logic                  Enable,
  input  logic                  FaultIn,
  input  logic                  FaultClear,
  input  logic                  PeriodSync,
  output logic [BIT_WIDTH-1:0]  Compare,
  output logic [BIT_WIDTH-1:0]  PWMMaxCount,
  output logic [BIT_WIDTH-1:0]  TriangleStepSize,
  output logic [BIT_WIDTH-1:0]  DeadTimeCount,
  output logic                  PWMRun,
  output logic [2:0]            RunState,
  output logic                  FaultLatched
);

  localparam int CNT_W = $clog2(FAULT_CLEAR_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAULT_CLEAR_HOLD - 1);

  cfg_t                 shadow, active;
  logic [BIT_WIDTH-1:0] rampShadow, rampActive;
  logic                 pending;
  logic                 cfgErrQ;
  run_state_t           state;
  logic [CNT_W-1:0]     clrCnt;
  logic [BIT_WIDTH-1:0] rampCur;

  logic accept, idleState, applyNow, commitOk, runPhase, rampAdvance;

  assign accept    = cfg.CfgValid && !pending;
  assign idleState = (state == DISABLED) || (state == FAULT);
  // pending only becomes visible the cycle after acceptance, so a PeriodSync
  // in the accept cycle is naturally skipped.
  assign applyNow  = pending && (idleState || PeriodSync);
  assign commitOk  = (shadow.maxCount != '0) && (shadow.stepSize != '0);
  assign runPhase  = (state == RUNNING) || (state == STOPPING);
  assign rampAdvance = (state == RUNNING) && PeriodSync && Enable && !FaultIn;

  assign cfg.CfgReady = !pending;
  assign cfg.CfgErr   = cfgErrQ;

  // ---- config shadow/active registers ----
  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      shadow     <= '0;
      active     <= '0;
      rampShadow <= '0;
      rampActive <= '0;
      pending    <= 1'b0;
      cfgErrQ    <= 1'b0;
    end else begin
      cfgErrQ <= 1'b0;
      if (accept) begin
        case (cfg.CfgAddr)
          ADDR_CMP:    shadow.compare  <= cfg.CfgData;
          ADDR_MAX:    shadow.maxCount <= cfg.CfgData;
          ADDR_STEP:   shadow.stepSize <= cfg.CfgData;
          ADDR_DEAD:   shadow.deadTime <= cfg.CfgData;
          ADDR_RAMP:   rampShadow      <= cfg.CfgData;
          ADDR_COMMIT: pending         <= 1'b1;
          default:     cfgErrQ         <= 1'b1;
        endcase
      end
      if (applyNow) begin
        pending <= 1'b0;
        if (commitOk) begin
          active.compare  <= clampCmp(shadow.compare, shadow.maxCount);
          active.maxCount <= shadow.maxCount;
          active.stepSize <= shadow.stepSize;
          active.deadTime <= shadow.deadTime;
          rampActive      <= rampShadow;
        end else begin
          cfgErrQ <= 1'b1;
        end
      end
    end
  end

  // ---- run-control FSM ----
  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      state        <= DISABLED;
      PWMRun       <= 1'b0;
      FaultLatched <= 1'b0;
      clrCnt       <= '0;
    end else if (FaultIn) begin
      state        <= FAULT;
      PWMRun       <= 1'b0;
      FaultLatched <= 1'b1;
      clrCnt       <= '0;
    end else begin
      case (state)
        DISABLED: if (Enable && (active.maxCount != '0)) state <= ARMED;
        ARMED: begin
          if (!Enable) state <= DISABLED;
          else if (PeriodSync) begin
            state  <= RUNNING;
            PWMRun <= 1'b1;
          end
        end
        RUNNING: if (!Enable) state <= STOPPING;
        STOPPING: begin
          // A re-enable rejoins RUNNING even on the boundary cycle.
          if (Enable) state <= RUNNING;
          else if (PeriodSync) begin
            state  <= DISABLED;
            PWMRun <= 1'b0;
          end
        end
        FAULT: begin
          if (FaultClear && !Enable) begin
            if (clrCnt == CNT_LAST) begin
              state        <= DISABLED;
              FaultLatched <= 1'b0;
              clrCnt       <= '0;
            end else begin
              clrCnt <= clrCnt + 1'b1;
            end
          end else begin
            clrCnt <= '0;
          end
        end
        default: begin
          state  <= DISABLED;
          PWMRun <= 1'b0;
        end
      endcase
    end
  end

  // The ramp register is held at 0 outside the run phase so entry into
  // RUNNING starts from 0; the output gate zeroes Compare the same cycle
  // the state leaves the run phase.
  pwm_compare_ramp #(.BIT_WIDTH(BIT_WIDTH)) uRamp (
    .MClk    (MClk),
    .RstN    (RstN),
    .target  (active.compare),
    .step    (rampActive),
    .advance (rampAdvance),
    .clear   (!runPhase),
    .current (rampCur)
  );

  assign Compare          = runPhase ? rampCur : '0;
  assign PWMMaxCount      = active.maxCount;
  assign TriangleStepSize = active.stepSize;
  assign DeadTimeCount    = active.deadTime;
  assign RunState         = state;

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// Directed bench for pwm_config_sequencer.
module tb_pwm_config_sequencer;

  logic        MClk, RstN;
  logic        Enable, FaultIn, FaultClear, PeriodSync;
  logic [15:0] Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount;
  logic        PWMRun, FaultLatched;
  logic [2:0]  RunState;

  int errors = 0;
  int checks = 0;

  pwm_config_sequencer_if #(.BIT_WIDTH(16)) cfgBus ();

  pwm_config_sequencer #(.BIT_WIDTH(16), .FAULT_CLEAR_HOLD(4)) dut (
    .MClk             (MClk),
    .RstN             (RstN),
    .cfg              (cfgBus),
    .Enable           (Enable),
    .FaultIn          (FaultIn),
    .FaultClear       (FaultClear),
    .PeriodSync       (PeriodSync),
    .Compare          (Compare),
    .PWMMaxCount      (PWMMaxCount),
    .TriangleStepSize (TriangleStepSize),
    .DeadTimeCount    (DeadTimeCount),
    .PWMRun           (PWMRun),
    .RunState         (RunState),
    .FaultLatched     (FaultLatched)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge MClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfgWrite(input logic [2:0] addr, input logic [15:0] data);
    cfgBus.CfgValid = 1'b1;
    cfgBus.CfgAddr  = addr;
    cfgBus.CfgData  = data;
    tick();
    cfgBus.CfgValid = 1'b0;
  endtask

  task automatic sync();
    PeriodSync = 1'b1;
    tick();
    PeriodSync = 1'b0;
  endtask

  localparam logic [2:0] S_DIS = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2, S_STOP = 3'd3, S_FLT = 3'd4;

  initial begin
    RstN = 1'b0; Enable = 0; FaultIn = 0; FaultClear = 0; PeriodSync = 0;
    cfgBus.CfgValid = 0; cfgBus.CfgAddr = '0; cfgBus.CfgData = '0;
    tick(); tick();
    chk("rst_ready", cfgBus.CfgReady, 1);
    chk("rst_state", RunState, S_DIS);
    chk("rst_max", PWMMaxCount, 0);
    chk("rst_run", PWMRun, 0);
    chk("rst_err", cfgBus.CfgErr, 0);
    chk("rst_flt", FaultLatched, 0);
    RstN = 1'b1;
    tick();

    // Initial config, committed while DISABLED
    cfgWrite(3'd1, 16'd1000);
    cfgWrite(3'd2, 16'd1);
    cfgWrite(3'd3, 16'd10);
    cfgWrite(3'd0, 16'd600);
    cfgWrite(3'd4, 16'd200);
    chk("shadow_no_effect", PWMMaxCount, 0);
    cfgWrite(3'd5, 16'd0);
    chk("commit_ready_low", cfgBus.CfgReady, 0);
    chk("commit_not_yet", PWMMaxCount, 0);
    tick();
    chk("commit_ready_back", cfgBus.CfgReady, 1);
    chk("commit_max", PWMMaxCount, 1000);
    chk("commit_step", TriangleStepSize, 1);
    chk("commit_dead", DeadTimeCount, 10);
    chk("commit_cmp_idle", Compare, 0);

    // Enable and period-aligned start with ramp
    Enable = 1'b1;
    tick();
    chk("armed_state", RunState, S_ARM);
    chk("armed_run", PWMRun, 0);
    sync();
    chk("run_state", RunState, S_RUN);
    chk("run_pwmrun", PWMRun, 1);
    chk("ramp0", Compare, 0);
    sync(); chk("ramp200", Compare, 200);
    sync(); chk("ramp400", Compare, 400);
    sync(); chk("ramp600", Compare, 600);
    sync(); chk("ramp_hold", Compare, 600);

    // Commit while RUNNING waits for PeriodSync
    cfgWrite(3'd1, 16'd2000);
    cfgWrite(3'd5, 16'd0);
    for (int i = 0; i < 49; i++) begin
      chk("wait_ready", cfgBus.CfgReady, 0);
      chk("wait_max", PWMMaxCount, 1000);
      tick();
    end
    chk("wait_ready_last", cfgBus.CfgReady, 0);
    sync();
    chk("sync_max", PWMMaxCount, 2000);
    chk("sync_ready", cfgBus.CfgReady, 1);
    chk("sync_cmp", Compare, 600);

    // Commit accepted together with PeriodSync waits a further period
    cfgWrite(3'd3, 16'd20);
    cfgBus.CfgValid = 1'b1; cfgBus.CfgAddr = 3'd5; PeriodSync = 1'b1;
    tick();
    cfgBus.CfgValid = 1'b0; PeriodSync = 1'b0;
    chk("same_sync_dead", DeadTimeCount, 10);
    chk("same_sync_ready", cfgBus.CfgReady, 0);
    tick();
    chk("same_sync_dead2", DeadTimeCount, 10);
    sync();
    chk("next_sync_dead", DeadTimeCount, 20);

    // Rejected commit (step size 0)
    cfgWrite(3'd2, 16'd0);
    cfgWrite(3'd5, 16'd0);
    sync();
    chk("rej_err", cfgBus.CfgErr, 1);
    chk("rej_ready", cfgBus.CfgReady, 1);
    chk("rej_step", TriangleStepSize, 1);
    chk("rej_max", PWMMaxCount, 2000);
    cfgWrite(3'd2, 16'd1);
    chk("rej_err_pulse", cfgBus.CfgErr, 0);

    // Reserved address
    cfgWrite(3'd6, 16'd123);
    chk("rsv_err", cfgBus.CfgErr, 1);
    chk("rsv_ready", cfgBus.CfgReady, 1);
    tick();
    chk("rsv_err_pulse", cfgBus.CfgErr, 0);

    // Ramp down saturates at target 100
    cfgWrite(3'd0, 16'd100);
    cfgWrite(3'd5, 16'd0);
    sync(); chk("dn_apply", Compare, 600);
    sync(); chk("dn400", Compare, 400);
    sync(); sync(); chk("dn_sat100", Compare, 100);

    // RampStep 0 jumps; target clamps to max count
    cfgWrite(3'd4, 16'd0);
    cfgWrite(3'd0, 16'd5000);
    cfgWrite(3'd5, 16'd0);
    sync(); chk("clamp_apply", Compare, 100);
    sync(); chk("clamp_jump", Compare, 2000);

    // Fault while RUNNING and the clear hold
    FaultIn = 1'b1;
    tick();
    FaultIn = 1'b0; Enable = 1'b0;
    chk("flt_state", RunState, S_FLT);
    chk("flt_run", PWMRun, 0);
    chk("flt_latched", FaultLatched, 1);
    chk("flt_cmp", Compare, 0);
    FaultClear = 1'b1;
    tick(); tick(); tick();
    FaultClear = 1'b0;
    tick();
    chk("flt_break", RunState, S_FLT);
    FaultClear = 1'b1;
    tick(); tick(); tick();
    chk("flt_hold3", RunState, S_FLT);
    tick();
    FaultClear = 1'b0;
    chk("flt_exit", RunState, S_DIS);
    chk("flt_exit_latch", FaultLatched, 0);
    chk("flt_retain", PWMMaxCount, 2000);

    // Stop / re-enable / clean stop
    Enable = 1'b1;
    tick();
    sync();
    chk("rerun_zero", Compare, 0);
    sync();
    chk("rerun_jump", Compare, 2000);
    Enable = 1'b0;
    tick();
    chk("stop_state", RunState, S_STOP);
    chk("stop_run", PWMRun, 1);
    chk("stop_cmp", Compare, 2000);
    Enable = 1'b1;
    tick();
    chk("stop_resume", RunState, S_RUN);
    Enable = 1'b0;
    tick(); tick();
    chk("stop_wait", RunState, S_STOP);
    sync();
    chk("stop_done", RunState, S_DIS);
    chk("stop_done_run", PWMRun, 0);
    chk("stop_done_cmp", Compare, 0);

    // Fault wins over PeriodSync in STOPPING
    Enable = 1'b1;
    tick();
    sync();
    Enable = 1'b0;
    tick();
    chk("stop2_state", RunState, S_STOP);
    FaultIn = 1'b1; PeriodSync = 1'b1;
    tick();
    FaultIn = 1'b0; PeriodSync = 1'b0;
    chk("stopflt_state", RunState, S_FLT);
    chk("stopflt_run", PWMRun, 0);
    FaultClear = 1'b1;
    tick(); tick(); tick(); tick();
    FaultClear = 1'b0;
    chk("stopflt_exit", RunState, S_DIS);

    // Async reset mid-RUNNING
    Enable = 1'b1;
    tick();
    sync();
    sync();
    chk("prerst_cmp", Compare, 2000);
    #2 RstN = 1'b0;
    #1;
    chk("arst_cmp", Compare, 0);
    chk("arst_run", PWMRun, 0);
    chk("arst_state", RunState, S_DIS);
    chk("arst_max", PWMMaxCount, 0);
    chk("arst_ready", cfgBus.CfgReady, 1);
    tick();
    RstN = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
